// File: rtl/apb_cmd_sequencer.sv
// rtl/apb_cmd_sequencer.sv - queued register command APB master with wait states and timeout
// Optional poll-until-match reads are enabled by defining APB_SEQ_POLL_EN.
module apb_cmd_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
`ifdef APB_SEQ_POLL_EN
  input  logic                  cmd_poll,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic [DATA_WIDTH-1:0] cmd_match,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
`ifdef APB_SEQ_POLL_EN
    logic                  poll;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] match;
`endif
  } cmd_t;

  cmd_t            fifo_mem [DEPTH];
  cmd_t            head, wr_entry;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count, count_d;
  logic            full, empty, push, pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr];
  assign count_d   = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_comb begin
    wr_entry       = '0;
    wr_entry.write = cmd_write;
    wr_entry.addr  = cmd_addr;
    wr_entry.wdata = cmd_wdata;
`ifdef APB_SEQ_POLL_EN
    wr_entry.poll  = cmd_poll;
    wr_entry.mask  = cmd_mask;
    wr_entry.match = cmd_match;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_entry;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
    end
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d, done_rdata;
  logic                  rsp_valid_d, rsp_write_d, rsp_err_d, busy_d;
  logic                  done, done_err;
`ifdef APB_SEQ_POLL_EN
  logic                  poll_q, poll_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d, match_q, match_d, last_q, last_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    rsp_valid_d = rsp_valid && !rsp_ready;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    done        = 1'b0;
    done_err    = 1'b0;
    done_rdata  = '0;
`ifdef APB_SEQ_POLL_EN
    poll_d      = poll_q;
    mask_d      = mask_q;
    match_d     = match_q;
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        // Only start when the response slot will be free, so completion never drops a response.
        if (!empty && (!rsp_valid || rsp_ready)) begin
          pop       = 1'b1;
          state_d   = SETUP;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = head.addr;
          pwrite_d  = head.write;
          pwdata_d  = head.wdata;
`ifdef APB_SEQ_POLL_EN
          poll_d    = head.poll && !head.write;
          mask_d    = head.mask;
          match_d   = head.match;
          last_d    = '0;
`endif
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_SEQ_POLL_EN
        if (poll_q) begin
          if (cnt_q == CNT_LAST) begin
            done       = 1'b1;
            done_err   = 1'b1;
            done_rdata = last_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      ACCESS: begin
        if (PREADY) begin
`ifdef APB_SEQ_POLL_EN
          last_d = PRDATA;
          if (poll_q && ((PRDATA & mask_q) != match_q)) begin
            if (cnt_q == CNT_LAST) begin
              done       = 1'b1;
              done_err   = 1'b1;
              done_rdata = PRDATA;
            end else begin
              state_d   = SETUP;
              penable_d = 1'b0;
              cnt_d     = cnt_q + 1'b1;
            end
          end else
`endif
          begin
            done       = 1'b1;
            done_rdata = PWRITE ? '0 : PRDATA;
          end
        end else if (cnt_q == CNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
`ifdef APB_SEQ_POLL_EN
          done_rdata = last_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d     = IDLE;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      paddr_d     = '0;
      pwdata_d    = '0;
      rsp_valid_d = 1'b1;
      rsp_write_d = PWRITE;
      rsp_err_d   = done_err;
      rsp_rdata_d = done_rdata;
    end
    busy_d = (count_d != '0) || (state_d != IDLE) || rsp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef APB_SEQ_POLL_EN
      poll_q    <= 1'b0;
      mask_q    <= '0;
      match_q   <= '0;
      last_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
`ifdef APB_SEQ_POLL_EN
      poll_q    <= poll_d;
      mask_q    <= mask_d;
      match_q   <= match_d;
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb/tb_apb_cmd_sequencer.sv - directed self-checking bench for apb_cmd_sequencer
module tb_apb_cmd_sequencer;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
`ifdef APB_SEQ_POLL_EN
  localparam int TO = 8;
`else
  localparam int TO = 4;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY = 1'b1;
  logic          use_map = 1'b0;
  logic [DW-1:0] prdata_v = '0;
`ifdef APB_SEQ_POLL_EN
  logic          cmd_poll = 1'b0;
  logic [DW-1:0] cmd_mask = '0, cmd_match = '0;
`endif

  // Address-mapped read data lets in-order responses be told apart.
  assign PRDATA = use_map ? {24'hA5A5A5, PADDR} : prdata_v;

  always #5 clk = ~clk;

  apb_cmd_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef APB_SEQ_POLL_EN
    .cmd_poll(cmd_poll), .cmd_mask(cmd_mask), .cmd_match(cmd_match),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    int got;

    // Reset state
    tick(); tick();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_paddr", PADDR, 0);

    // Write 0x04 <- 0xDEADBEEF, zero-wait slave
    PREADY = 1'b1;
    push(1'b1, 8'h04, 32'hDEADBEEF);
    check("wr_n_psel", PSEL, 0);
    check("wr_n_busy", busy, 1);
    tick();
    check("wr_n1_psel", PSEL, 1);
    check("wr_n1_penable", PENABLE, 0);
    check("wr_n1_paddr", PADDR, 32'h04);
    check("wr_n1_pwrite", PWRITE, 1);
    check("wr_n1_pwdata", PWDATA, 32'hDEADBEEF);
    tick();
    check("wr_n2_psel", PSEL, 1);
    check("wr_n2_penable", PENABLE, 1);
    check("wr_n2_pwdata", PWDATA, 32'hDEADBEEF);
    tick();
    check("wr_n3_psel", PSEL, 0);
    check("wr_n3_penable", PENABLE, 0);
    check("wr_n3_rsp_valid", rsp_valid, 1);
    check("wr_n3_rsp_write", rsp_write, 1);
    check("wr_n3_rsp_err", rsp_err, 0);
    check("wr_n3_rsp_rdata", rsp_rdata, 0);
    check("wr_n3_paddr_zero", PADDR, 0);
    check("wr_n3_pwdata_zero", PWDATA, 0);
    accept();

    // Read 0x08 with three wait states
    prdata_v = 32'h12345678;
    PREADY = 1'b0;
    push(1'b0, 8'h08, 32'h0);
    tick();
    check("rd_setup_psel", PSEL, 1);
    tick();
    check("rd_access_penable", PENABLE, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_wait_penable", PENABLE, 1);
      check("rd_wait_paddr", PADDR, 32'h08);
      check("rd_wait_rsp_valid", rsp_valid, 0);
    end
    PREADY = 1'b1;
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_psel_off", PSEL, 0);
    accept();

    // Timeout with a queued command behind it
    prdata_v = 32'hFFFF0000;
    PREADY = 1'b0;
    push(1'b0, 8'h0C, 32'h0);
    push(1'b1, 8'h20, 32'h0000A5A5);
    check("to_setup_psel", PSEL, 1);
    tick();
    check("to_access_penable", PENABLE, 1);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_wait_penable", PENABLE, 1);
    end
    tick();
    check("to_abort_psel", PSEL, 0);
    check("to_abort_penable", PENABLE, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_next_psel", PSEL, 1);
    check("to_next_paddr", PADDR, 32'h20);
    check("to_next_rsp_cleared", rsp_valid, 0);
    tick();
    tick();
    check("to_next_rsp_valid", rsp_valid, 1);
    check("to_next_rsp_err", rsp_err, 0);
    check("to_next_rsp_write", rsp_write, 1);
    accept();

    // Fill: nine commands with the response slot blocked
    use_map = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("fill_cmd_ready", cmd_ready, 1);
      push(1'b0, 8'(8'h40 + i), 32'h0);
    end
    check("fill_full", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fill_hold_psel", PSEL, 0);
      check("fill_hold_ready", cmd_ready, 0);
      check("fill_hold_rsp", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && got < 9; t++) begin
      if (rsp_valid) begin
        check("fill_rdata", rsp_rdata, 32'hA5A5A540 + 32'(got));
        got++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("fill_count", 32'(got), 9);
    check("fill_idle_busy", busy, 0);
    check("fill_idle_ready", cmd_ready, 1);
    use_map = 1'b0;

    // Reset during ACCESS discards in-flight and queued work
    PREADY = 1'b0;
    push(1'b1, 8'h30, 32'h11111111);
    push(1'b1, 8'h34, 32'h22222222);
    tick();
    check("rstmid_penable", PENABLE, 1);
    reset = 1'b1;
    tick();
    check("rstmid_psel", PSEL, 0);
    check("rstmid_penable0", PENABLE, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rstmid_cmd_ready", cmd_ready, 1);
    tick();
    check("rstmid_no_start", PSEL, 0);
    check("rstmid_busy_after", busy, 0);
    PREADY = 1'b1;

`ifdef APB_SEQ_POLL_EN
    // Poll 0x10 until bit 0 is set; slave returns 0, 0, 1
    begin
      int n_acc;
      int n_rsp;
      logic [DW-1:0] last_rdata;
      n_acc = 0;
      n_rsp = 0;
      last_rdata = '1;
      prdata_v = 32'h0;
      rsp_ready = 1'b1;
      cmd_poll = 1'b1;
      cmd_mask = 32'h1;
      cmd_match = 32'h1;
      push(1'b0, 8'h10, 32'h0);
      cmd_poll = 1'b0;
      for (int t = 0; t < 30; t++) begin
        tick();
        if (PSEL && PENABLE) begin
          n_acc++;
          prdata_v = (n_acc >= 3) ? 32'h1 : 32'h0;
        end
        if (rsp_valid) begin
          n_rsp++;
          last_rdata = rsp_rdata;
        end
      end
      rsp_ready = 1'b0;
      check("poll_reads", 32'(n_acc), 3);
      check("poll_rsps", 32'(n_rsp), 1);
      check("poll_rdata", last_rdata, 32'h1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
Name: apb_cmd_sequencer

Overview:
Synthesizable APB master that replaces the bench's hand-driven register write/read sequences.
- Accepts queued register commands (write/read) on a valid/ready interface.
- Executes each as a compliant APB transfer (SETUP then ACCESS) into the configuration block, with PREADY wait states and a timeout.
- Returns one response per command on a valid/ready response interface.
- Sits between a host/control FSM and the config slave.

Parameters:
ADDR_WIDTH, 8, APB address width (PADDR, cmd_addr).
DATA_WIDTH, 32, APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata).
DEPTH, 8, command FIFO entries; power of two, >= 2.
TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY before abort; >= 1.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; equals !full (combinational from registered count).
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  register address.
cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
rsp_valid  out  1  response held until accepted.
rsp_ready  in  1  response consumer ready.
rsp_write  out  1  echo of the command type.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
rsp_err  out  1  1 = transfer timed out.
busy  out  1  FIFO non-empty, or FSM not IDLE, or rsp_valid.
PADDR  out  ADDR_WIDTH  APB address.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWDATA  out  DATA_WIDTH  APB write data.
PRDATA  in  DATA_WIDTH  APB read data.
PREADY  in  1  APB ready.

Behaviour:
- Reset:
  - All outputs registered and reset to 0, except cmd_ready, which reads 1 once reset deasserts.
  - FIFO cleared, FSM to IDLE, timeout counter cleared.
  - Reset asserted mid-transfer drops PSEL/PENABLE at that edge and discards any in-flight command and response.
- FIFO:
  - Push on cmd_valid && cmd_ready; pop when the FSM leaves IDLE.
  - Push and pop in the same cycle are both honored; count unchanged.
  - When full, cmd_ready = 0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when FIFO non-empty AND (rsp_valid == 0 OR rsp_ready == 1). The head entry loads PADDR/PWRITE/PWDATA and PSEL = 1, PENABLE = 0.
  - SETUP -> ACCESS unconditionally: PENABLE = 1; PADDR/PWRITE/PWDATA held stable.
  - In ACCESS, PREADY == 1 completes the transfer:
    - rsp_valid = 1, rsp_write = PWRITE, rsp_err = 0.
    - rsp_rdata = PRDATA for reads, 0 for writes.
    - PSEL = 0, PENABLE = 0, go to IDLE.
  - In ACCESS, PREADY == 0 increments the wait counter. When it reaches TIMEOUT:
    - Abort: PSEL = 0, PENABLE = 0.
    - Response: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
    - Go to IDLE.
  - PADDR and PWDATA return to 0 whenever PSEL = 0.
- Response slot: single entry; rsp_valid clears on rsp_valid && rsp_ready. The IDLE start condition guarantees the slot is free at every completion, so no response is ever dropped.
- Latency: command pushed at edge N, empty FIFO, free slot, PREADY tied 1:
  - PSEL high after edge N+1.
  - PENABLE high after N+2.
  - rsp_valid high after N+3.
  - Minimum 3 cycles per transfer; a new SETUP may start the cycle after completion.
- Commands execute strictly in order; responses are in order.

Optional Feature:
Macro APB_SEQ_POLL_EN.
- When defined, adds three ports:
  - cmd_poll in 1.
  - cmd_mask in DATA_WIDTH.
  - cmd_match in DATA_WIDTH.
- A read command with cmd_poll = 1 repeats the APB read (SETUP/ACCESS) until (PRDATA & mask) == match.
- Only the matching read produces a response.
- The timeout counter spans the whole poll, counting every cycle from the first SETUP; expiry gives rsp_err = 1 and rsp_rdata = last PRDATA.
- When undefined, these ports and the poll logic are absent, and every command yields exactly one APB transfer.

Test Plan:
- Write 0x04 <- 0xDEADBEEF, PREADY = 1 -> PSEL at N+1, PENABLE at N+2, PWDATA = 0xDEADBEEF stable both cycles; rsp_valid at N+3 with rsp_write = 1, rsp_err = 0, rsp_rdata = 0.
- Read 0x08, slave drives PRDATA = 0x12345678 with PREADY low for 3 ACCESS cycles -> PENABLE held 4 cycles, address stable; rsp_rdata = 0x12345678.
- TIMEOUT = 4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_err = 1, rsp_rdata = 0; next queued command then runs normally.
- Push 9 commands with rsp_ready = 0 (DEPTH = 8) -> one transfer completes, 8 queued, cmd_ready = 0 while full; no second SETUP until rsp_ready = 1; all 9 responses arrive in order.
- Assert reset during ACCESS -> PSEL/PENABLE/rsp_valid are 0 after that edge, FIFO empty, busy = 0, cmd_ready = 1 after release.
- APB_SEQ_POLL_EN: poll 0x10, mask 0x1, match 0x1; slave returns 0, 0, 1 -> three APB reads, single response with rsp_rdata = 0x1.
